// File: rtl/ex_muldiv_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_muldiv_ctrl_pkg                                                   |
// | RV32M funct3 op codes and multiply/divide controller state encoding. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ex_muldiv_ctrl_pkg;

  localparam logic [2:0] c_MUL    = 3'b000;
  localparam logic [2:0] c_MULH   = 3'b001;
  localparam logic [2:0] c_MULHSU = 3'b010;
  localparam logic [2:0] c_MULHU  = 3'b011;
  localparam logic [2:0] c_DIV    = 3'b100;
  localparam logic [2:0] c_DIVU   = 3'b101;
  localparam logic [2:0] c_REM    = 3'b110;
  localparam logic [2:0] c_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_ctrl_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_step                                                          |
// | One shift-add (multiply) or restoring shift-subtract (divide) step.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_rem_sh;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_b} : '0);
    // The shifted partial remainder can reach 2*divisor, so it needs XLEN+1 bits.
    w_rem_sh = i_acc[2*XLEN-1:XLEN-1];
    w_ge     = (w_rem_sh >= {1'b0, i_b});
    w_diff   = w_rem_sh[XLEN-1:0] - i_b;
    if (i_is_div) begin
      if (w_ge) o_acc = {w_diff, i_acc[XLEN-2:0], 1'b1};
      else      o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ex_muldiv_ctrl                                                       |
// | Iterative RV32M multiply/divide unit with EX-stage stall handshake.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] c_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state, w_next_state;
  logic [4:0]        r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [2:0]        r_funct3;
  logic              r_neg;
  logic              r_neg_rem;
  logic [XLEN-1:0]   r_result;

  logic              w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div_zero, w_ovf, w_fast;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_load, w_fast_load, w_step, w_finish;
  logic [2*XLEN-1:0] w_acc_next, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_fix;

  always_comb begin
    w_a_signed = (funct3 == c_MUL) || (funct3 == c_MULH) || (funct3 == c_MULHSU) ||
                 (funct3 == c_DIV) || (funct3 == c_REM);
    w_b_signed = (funct3 == c_MUL) || (funct3 == c_MULH) ||
                 (funct3 == c_DIV) || (funct3 == c_REM);
    w_a_neg    = w_a_signed & op_a[XLEN-1];
    w_b_neg    = w_b_signed & op_b[XLEN-1];
    w_a_mag    = w_a_neg ? -op_a : op_a;
    w_b_mag    = w_b_neg ? -op_b : op_b;
    w_div_zero = funct3[2] && (op_b == '0);
    w_ovf      = ((funct3 == c_DIV) || (funct3 == c_REM)) &&
                 (op_a == c_MIN_NEG) && (op_b == '1);
    w_fast     = w_div_zero | w_ovf;
    if (w_div_zero) w_fast_res = funct3[1] ? op_a : '1;
    else            w_fast_res = funct3[1] ? '0 : c_MIN_NEG;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (r_funct3[2]),
    .i_acc    (r_acc),
    .i_b      (r_b),
    .o_acc    (w_acc_next)
  );

  // Sign fix-up works on the final step output so it lands on the DONE entry edge.
  always_comb begin
    w_prod = r_neg ? -w_acc_next : w_acc_next;
    w_quo  = r_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
    w_rem  = r_neg_rem ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
    case (r_funct3)
      c_MUL:                      w_fix = w_prod[XLEN-1:0];
      c_MULH, c_MULHSU, c_MULHU:  w_fix = w_prod[2*XLEN-1:XLEN];
      c_DIV, c_DIVU:              w_fix = w_quo;
      default:                    w_fix = w_rem;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_fast_load  = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !flush) begin
          if (w_fast) begin
            w_next_state = ST_DONE;
            w_fast_load  = 1'b1;
          end else begin
            w_next_state = ST_BUSY;
            w_load       = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        w_step = 1'b1;
        if (r_cnt == 5'd31) begin
          w_next_state = ST_DONE;
          w_finish     = 1'b1;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (flush) begin
      w_next_state = ST_IDLE;
      w_load       = 1'b0;
      w_fast_load  = 1'b0;
      w_step       = 1'b0;
      w_finish     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_funct3  <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_cnt     <= '0;
        r_acc     <= {{XLEN{1'b0}}, w_a_mag};
        r_b       <= w_b_mag;
        r_funct3  <= funct3;
        r_neg     <= w_a_neg ^ w_b_neg;
        r_neg_rem <= w_a_neg;
      end else if (w_step) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_fast_load) r_result <= w_fast_res;
      if (w_finish)    r_result <= w_fix;
    end
  end

  assign stall  = rst_n & (((r_state == ST_IDLE) & start & ~flush) | (r_state == ST_BUSY));
  assign done   = (r_state == ST_DONE) & ~flush;
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ex_muldiv_ctrl                                                    |
// | Self-checking bench: vector table, scoreboard queue, corner cases.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  ex_muldiv_ctrl #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; drives start immediately so the next rising edge samples it.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int n;
    int stall_low;
    logic [31:0] want;
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    sb.push_back(exp);
    #1;
    check("stall_start", {31'b0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    stall_low = 0;
    while (done !== 1'b1 && n < 40) begin
      if (stall !== 1'b1) stall_low++;
      @(negedge clk);
      n++;
    end
    want = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check("done_seen", {31'b0, done}, 32'd1);
    check("latency", n, lat);
    check("stall_busy_low_cycles", stall_low, 0);
    check("stall_in_done", {31'b0, stall}, 32'd0);
    check("result", result, want);
    @(negedge clk);
    check("done_single", {31'b0, done}, 32'd0);
    check("result_hold", result, want);
  endtask

  initial begin
    int dcount;
    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{3'b101, 32'd100,       32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[12] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33};
    vecs[13] = '{3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33};
    vecs[14] = '{3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 33};
    vecs[15] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};

    rst_n = 1'b0; start = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Flush at BUSY iteration 10, then a fresh multiply.
    start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_stall", {31'b0, stall}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("flush_no_done", dcount, 0);
    do_op(3'b000, 32'd3, 32'd4, 32'd12, 33);

    // Reset in mid-BUSY clears everything, and start is accepted on the first edge after.
    start = 1'b1; funct3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_stall", {31'b0, stall}, 32'd0);
    check("midreset_done", {31'b0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    rst_n = 1'b1;
    do_op(3'b101, 32'd100, 32'd7, 32'd14, 33);

    // start held high: each accepted op yields exactly one single-cycle done.
    start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd4;
    sb.push_back(32'd12);
    sb.push_back(32'd12);
    dcount = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcount++;
        check("held_result", result, (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF);
        if (i != 32 && i != 66) check("held_done_cycle", i, (dcount == 1) ? 32 : 66);
      end
    end
    start = 1'b0;
    check("held_done_count", dcount, 2);
    check("scoreboard_empty", sb.size(), 0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
